gemm_stream_sequencer: RTL



---
 rtl/gemm_stream_sequencer_pkg.sv | 17 +
 rtl/gemm_vec_out_reg.sv | 29 ++
 rtl/gemm_stream_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/gemm_stream_sequencer_pkg.sv
// Shared types and helpers for the GEMM stream sequencer.
package gemm_stream_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } seq_state_e;

  // Zero cycles needed for the last skewed operand to cross an SA_SIZE x SA_SIZE array.
  function automatic int drain_cycles(input int sa_size);
    return 3 * sa_size - 2;
  endfunction

endpackage

// File: rtl/gemm_vec_out_reg.sv
// Registered activation/weight vector pair: each cycle either loads the new pair or zeros it.
module gemm_vec_out_reg #(
  parameter int LANES  = 8,
  parameter int ELEM_W = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         load,
  input  logic [LANES-1:0][ELEM_W-1:0] data_a,
  input  logic [LANES-1:0][ELEM_W-1:0] data_b,
  output logic [LANES-1:0][ELEM_W-1:0] q_a,
  output logic [LANES-1:0][ELEM_W-1:0] q_b
);

  // A and B share one load select so a bubble can never skew them apart.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_a <= '0;
      q_b <= '0;
    end else if (load) begin
      q_a <= data_a;
      q_b <= data_b;
    end else begin
      q_a <= '0;
      q_b <= '0;
    end
  end

endmodule

// File: rtl/gemm_stream_sequencer.sv
// Sequences one output-stationary GEMM tile pass: clear, stream K vector pairs, drain, done.
// Optional bubble_cnt statistics output is enabled by defining GEMM_BUBBLE_STATS_EN.
module gemm_stream_sequencer
  import gemm_stream_sequencer_pkg::*;
#(
  parameter int SA_SIZE         = 8,
  parameter int ACTIVATION_SIZE = 32,
  parameter int K_W             = 16
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic                                      start,
  input  logic [K_W-1:0]                            k_len,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      acc_clear,
  input  logic                                      src_valid,
  output logic                                      src_ready,
  input  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]   src_a,
  input  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]   src_b,
  output logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]   a_out,
  output logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]   b_out
`ifdef GEMM_BUBBLE_STATS_EN
  ,
  output logic [K_W+SA_SIZE-1:0]                    bubble_cnt
`endif
);

  localparam int DRAIN_N = drain_cycles(SA_SIZE);
  localparam int DC_W    = $clog2(DRAIN_N + 1);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_CLEAR  = CLEAR;
  localparam logic [2:0] ST_STREAM = STREAM;
  localparam logic [2:0] ST_DRAIN  = DRAIN;
  localparam logic [2:0] ST_DONE   = DONE;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [K_W-1:0]  k_lat;
  logic [K_W-1:0]  beat_cnt;
  logic [K_W-1:0]  beat_inc;
  logic [DC_W-1:0] drain_cnt;
  logic            accept;
  logic            last_beat;
  logic            drain_end;

  assign src_ready = (state == ST_STREAM);
  assign accept    = src_valid & src_ready;
  assign beat_inc  = beat_cnt + K_W'(1);
  // Equality on the incremented count: k_len = 2^K_W-1 is reached without wrapping.
  assign last_beat = accept && (beat_inc == k_lat);
  // The first DRAIN cycle still shows the last beat, so DRAIN_N zero cycles need DRAIN_N+1 states.
  assign drain_end = (drain_cnt == DC_W'(DRAIN_N));

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign acc_clear = (state == ST_CLEAR);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_CLEAR;
      ST_CLEAR:  state_nxt = (k_lat != '0) ? ST_STREAM : ST_DONE;
      ST_STREAM: if (last_beat) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (drain_end) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      k_lat     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) k_lat <= k_len;
      if (state == ST_CLEAR) beat_cnt <= '0;
      else if (accept)       beat_cnt <= beat_inc;
      if (state == ST_DRAIN && !drain_end) drain_cnt <= drain_cnt + DC_W'(1);
      else                                 drain_cnt <= '0;
    end
  end

  gemm_vec_out_reg #(
    .LANES  (SA_SIZE),
    .ELEM_W (ACTIVATION_SIZE)
  ) u_vec_out (
    .clk    (clk),
    .resetn (resetn),
    .load   (accept),
    .data_a (src_a),
    .data_b (src_b),
    .q_a    (a_out),
    .q_b    (b_out)
  );

`ifdef GEMM_BUBBLE_STATS_EN
  localparam int BW = K_W + SA_SIZE;

  // Counts STREAM cycles without an accepted beat; saturates rather than wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bubble_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      bubble_cnt <= '0;
    end else if (state == ST_STREAM && !accept && bubble_cnt != '1) begin
      bubble_cnt <= bubble_cnt + BW'(1);
    end
  end
`endif

endmodule
